// File: rtl/branch_predictor_gshare.sv
// gshare branch predictor: PC[IDX_BITS+1:2] XOR global history indexes a table of saturating counters.
// Define BPRED_STATS_EN to add the Prediction_EX input and the BranchCount/MissCount statistics outputs.
module branch_predictor_gshare #(
  parameter int HIST_BITS = 4,
  parameter int IDX_BITS  = 6,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 BranchExists_ID,
  input  logic [31:0]          PC_ID,
  input  logic                 BranchExists_EX,
  input  logic                 BranchDecision_EX,
  input  logic [IDX_BITS-1:0]  Index_EX,
`ifdef BPRED_STATS_EN
  input  logic                 Prediction_EX,
  output logic [31:0]          BranchCount,
  output logic [31:0]          MissCount,
`endif
  output logic                 Prediction,
  output logic [IDX_BITS-1:0]  PredIndex_ID,
  output logic                 Ready,
  output logic [HIST_BITS-1:0] History
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_reg, state_next;
  logic [IDX_BITS-1:0]   ptr_reg, ptr_next;
  logic [HIST_BITS-1:0]  hist_reg, hist_shift;
  logic [CTR_BITS-1:0]   pht [DEPTH];
  logic [CTR_BITS-1:0]   ctr_cur, ctr_upd;
  logic                  update;

  // Only the index field of the PC takes part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, PC_ID[31:IDX_BITS+2], PC_ID[1:0]};

  assign Ready   = (state_reg == RUN);
  assign update  = Ready & BranchExists_EX;
  assign History = hist_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= INIT;
      ptr_reg   <= '0;
      hist_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (update) hist_reg <= hist_shift;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      INIT: begin
        ptr_next = ptr_reg + 1'b1;
        if (&ptr_reg) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  generate
    if (HIST_BITS == 1) begin : g_hist_one
      assign hist_shift = BranchDecision_EX;
    end else begin : g_hist_multi
      assign hist_shift = {hist_reg[HIST_BITS-2:0], BranchDecision_EX};
    end
  endgenerate

  assign ctr_cur = pht[Index_EX];

  always_comb begin
    ctr_upd = ctr_cur;
    if (BranchDecision_EX) begin
      if (ctr_cur != CTR_MAX) ctr_upd = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_upd = ctr_cur - 1'b1;
    end
  end

  // Table is not reset: the sweep rewrites it and Ready masks stale contents meanwhile.
  always_ff @(posedge clock) begin
    if (state_reg == INIT) pht[ptr_reg] <= WNT;
    else if (update)       pht[Index_EX] <= ctr_upd;
  end

  assign PredIndex_ID = PC_ID[IDX_BITS+1:2] ^ IDX_BITS'(hist_reg);
  assign Prediction   = BranchExists_ID & Ready & pht[PredIndex_ID][CTR_BITS-1];

`ifdef BPRED_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      BranchCount <= '0;
      MissCount   <= '0;
    end else if (update) begin
      if (BranchCount != 32'hFFFF_FFFF) BranchCount <= BranchCount + 32'd1;
      if ((Prediction_EX != BranchDecision_EX) && (MissCount != 32'hFFFF_FFFF))
        MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench for branch_predictor_gshare: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
`timescale 1ns/1ps
module tb_branch_predictor_gshare;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        BranchExists_ID = 1'b0;
  logic [31:0] PC_ID = '0;
  logic        BranchExists_EX = 1'b0;
  logic        BranchDecision_EX = 1'b0;
  logic [5:0]  Index_EX = '0;
  logic        Prediction;
  logic [5:0]  PredIndex_ID;
  logic        Ready;
  logic [3:0]  History;
`ifdef BPRED_STATS_EN
  logic        Prediction_EX = 1'b0;
  logic [31:0] BranchCount;
  logic [31:0] MissCount;
`endif

  int checks = 0;
  int errors = 0;

  branch_predictor_gshare dut (
    .clock             (clock),
    .reset             (reset),
    .BranchExists_ID   (BranchExists_ID),
    .PC_ID             (PC_ID),
    .BranchExists_EX   (BranchExists_EX),
    .BranchDecision_EX (BranchDecision_EX),
    .Index_EX          (Index_EX),
`ifdef BPRED_STATS_EN
    .Prediction_EX     (Prediction_EX),
    .BranchCount       (BranchCount),
    .MissCount         (MissCount),
`endif
    .Prediction        (Prediction),
    .PredIndex_ID      (PredIndex_ID),
    .Ready             (Ready),
    .History           (History)
  );

  always #5 clock = ~clock;

  // mask: [0] Ready, [1] Prediction, [2] PredIndex_ID, [3] History, [4] statistics
  typedef struct {
    string       name;
    logic [4:0]  mask;
    logic        ready;
    logic        pred;
    logic [5:0]  idx;
    logic [3:0]  hist;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_out(input string name, input logic [4:0] mask, input logic r,
                            input logic p, input logic [5:0] i, input logic [3:0] h);
    exp_t e;
    e.name = name; e.mask = mask; e.ready = r; e.pred = p; e.idx = i; e.hist = h;
    e.bc = '0; e.mc = '0;
    sb_q.push_back(e);
  endtask

  task automatic expect_stats(input string name, input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.name = name; e.mask = 5'b10000; e.ready = 1'b0; e.pred = 1'b0; e.idx = '0; e.hist = '0;
    e.bc = bc; e.mc = mc;
    sb_q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic [31:0] act_bc, act_mc;
`ifdef BPRED_STATS_EN
    act_bc = BranchCount; act_mc = MissCount;
`else
    act_bc = '0; act_mc = '0;
`endif
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.mask[0]) begin
        checks++;
        if (Ready !== e.ready) begin
          errors++;
          $display("FAIL %s Ready: got %0b expected %0b", e.name, Ready, e.ready);
        end
      end
      if (e.mask[1]) begin
        checks++;
        if (Prediction !== e.pred) begin
          errors++;
          $display("FAIL %s Prediction: got %0b expected %0b", e.name, Prediction, e.pred);
        end
      end
      if (e.mask[2]) begin
        checks++;
        if (PredIndex_ID !== e.idx) begin
          errors++;
          $display("FAIL %s PredIndex_ID: got %h expected %h", e.name, PredIndex_ID, e.idx);
        end
      end
      if (e.mask[3]) begin
        checks++;
        if (History !== e.hist) begin
          errors++;
          $display("FAIL %s History: got %b expected %b", e.name, History, e.hist);
        end
      end
      if (e.mask[4]) begin
        checks++;
        if (act_bc !== e.bc || act_mc !== e.mc) begin
          errors++;
          $display("FAIL %s stats: got branch=%0d miss=%0d expected branch=%0d miss=%0d",
                   e.name, act_bc, act_mc, e.bc, e.mc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic id_v, input logic [31:0] pc, input logic ex_v,
                       input logic dec, input logic [5:0] ix);
    BranchExists_ID = id_v; PC_ID = pc;
    BranchExists_EX = ex_v; BranchDecision_EX = dec; Index_EX = ix;
  endtask

  task automatic update_n(input logic [5:0] ix, input logic dec, input int n);
    drive(1'b0, 32'h0, 1'b1, dec, ix);
    repeat (n) tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
  endtask

  task automatic probe(input string name, input logic [31:0] pc, input logic p,
                       input logic [5:0] i, input logic [3:0] h);
    drive(1'b1, pc, 1'b0, 1'b0, 6'h0);
    expect_out(name, 5'b01111, 1'b1, p, i, h);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: reset state, sweep length, EX ignored during INIT
    drive(1'b1, 32'h40, 1'b0, 1'b0, 6'h0);
    #1;
    expect_out("reset_state", 5'b01111, 1'b0, 1'b0, 6'h10, 4'h0);
    tick(); tick();
    reset = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 1'b1, 6'h10);
    for (int i = 0; i < 64; i++) begin
      expect_out($sformatf("init_cycle_%0d", i + 1), 5'b01011, 1'b0, 1'b0, 6'h0, 4'h0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
    expect_out("ready_after_sweep", 5'b01001, 1'b1, 1'b0, 6'h0, 4'h0);
    tick();
    for (int i = 0; i < 64; i++) begin
      logic [5:0] ii;
      ii = 6'(i);
      drive(1'b1, {24'h0, ii, 2'b00}, 1'b0, 1'b0, 6'h0);
      expect_out($sformatf("sweep_wnt_%0d", i), 5'b01111, 1'b1, 1'b0, ii, 4'h0);
      tick();
    end

    // Test 2: two taken updates on 0x10
    drive(1'b1, 32'h40, 1'b1, 1'b1, 6'h10);
    expect_out("t2_first", 5'b01111, 1'b1, 1'b0, 6'h10, 4'h0);
    tick();
    expect_out("t2_second", 5'b01111, 1'b1, 1'b0, 6'h11, 4'h1);
    tick();
    probe("t2_probe", 32'h4C, 1'b1, 6'h10, 4'h3);

    // Test 3: saturation at entry 0x05
    update_n(6'h05, 1'b1, 5);
    probe("t3_sat_hi", 32'h28, 1'b1, 6'h05, 4'hF);
    update_n(6'h05, 1'b0, 1);
    probe("t3_dec_to2", 32'h2C, 1'b1, 6'h05, 4'hE);
    update_n(6'h05, 1'b0, 1);
    probe("t3_dec_to1", 32'h24, 1'b0, 6'h05, 4'hC);
    update_n(6'h05, 1'b0, 3);
    probe("t3_sat_lo", 32'h14, 1'b0, 6'h05, 4'h0);
    update_n(6'h05, 1'b1, 1);
    probe("t3_inc_from0", 32'h10, 1'b0, 6'h05, 4'h1);
    update_n(6'h05, 1'b1, 1);
    probe("t3_inc_to2", 32'h18, 1'b1, 6'h05, 4'h3);

    // Test 4: decisions 1,0,1,1,0 with read-before-write on the 5th
    update_n(6'h0B, 1'b1, 1);
    update_n(6'h0B, 1'b0, 1);
    update_n(6'h0B, 1'b1, 1);
    update_n(6'h20, 1'b1, 1);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 6'h0B);
    expect_out("t4_same_cycle", 5'b01111, 1'b1, 1'b1, 6'h0B, 4'hB);
    tick();
    probe("t4_after", 32'h34, 1'b0, 6'h0B, 4'h6);

    // Test 5: async reset in RUN, reset mid-INIT restarts the sweep
    update_n(6'h20, 1'b1, 4);
    expect_out("t5_hist_pre", 5'b01001, 1'b1, 1'b0, 6'h0, 4'hF);
    tick();
    reset = 1'b1;
    expect_out("t5_async_reset", 5'b01001, 1'b0, 1'b0, 6'h0, 4'h0);
    tick(); tick();
    reset = 1'b0;
    repeat (29) tick();
    expect_out("t5_mid_init", 5'b00001, 1'b0, 1'b0, 6'h0, 4'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      expect_out($sformatf("reinit_cycle_%0d", i + 1), 5'b00001, 1'b0, 1'b0, 6'h0, 4'h0);
      tick();
    end
    expect_out("reinit_ready", 5'b01001, 1'b1, 1'b0, 6'h0, 4'h0);
    tick();
    for (int i = 0; i < 64; i++) begin
      logic [5:0] ii;
      ii = 6'(i);
      drive(1'b1, {24'h0, ii, 2'b00}, 1'b0, 1'b0, 6'h0);
      expect_out($sformatf("reinit_wnt_%0d", i), 5'b01111, 1'b1, 1'b0, ii, 4'h0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'h0);

`ifdef BPRED_STATS_EN
    // Test 6: 10 updates, misses on steps 2, 5 and 8
    expect_stats("stats_reset", 32'd0, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      logic dec;
      dec = i[0];
      drive(1'b0, 32'h0, 1'b1, dec, 6'h30);
      Prediction_EX = (i == 2 || i == 5 || i == 8) ? ~dec : dec;
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
    Prediction_EX = 1'b0;
    expect_stats("stats_counts", 32'd10, 32'd3);
    tick();
`endif

    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
